// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with operand forwarding,
// load-use hazard detection, bubble insertion and a saturating stall counter.
module id_ex_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ALU_OP_W = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_uses_rt,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic [DATA_W-1:0]   id_rdata1,
    input  logic [DATA_W-1:0]   id_rdata2,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_alu_src_imm,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic [DATA_W-1:0]   ex_alu_result,
    input  logic [REG_AW-1:0]   wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                wb_we,
    input  logic                flush,
    output logic                stall_out,
    output logic                ex_valid,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src_imm,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic [DATA_W-1:0]   ex_op_a,
    output logic [DATA_W-1:0]   ex_op_b,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [CNT_W-1:0]    stall_count
);

    logic                valid_q, valid_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic                src_imm_q, src_imm_d;
    logic                reg_write_q, reg_write_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                hazard;
    logic                ex_fwd_ok;
    logic [DATA_W-1:0]   fwd_a, fwd_b;

    // Register 0 reads as zero; EX beats WB because it is the younger write.
    function automatic logic [DATA_W-1:0] select_operand(
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_ok,
        input logic [REG_AW-1:0] ex_dst,
        input logic [DATA_W-1:0] ex_res,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_dst,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] r;
        if (addr == '0)
            r = '0;
        else if (ex_ok && ex_dst == addr)
            r = ex_res;
        else if (wb_en && wb_dst == addr)
            r = wb_val;
        else
            r = rf_data;
        return r;
    endfunction

    // Load-use hazard detection and upstream stall request.
    always_comb begin
        hazard = id_valid && valid_q && mem_read_q && (rd_q != '0) &&
                 ((rd_q == id_rs) || (id_uses_rt && rd_q == id_rt));
        stall_out = hazard && !flush;
    end

    // Forwarding muxes for both source operands.
    always_comb begin
        ex_fwd_ok = valid_q && reg_write_q && !mem_read_q;
        fwd_a = select_operand(id_rs, id_rdata1, ex_fwd_ok, rd_q, ex_alu_result,
                               wb_we, wb_reg, wb_data);
        fwd_b = select_operand(id_rt, id_rdata2, ex_fwd_ok, rd_q, ex_alu_result,
                               wb_we, wb_reg, wb_data);
    end

    // Next-state: bubble on flush, hazard or empty slot; otherwise load decode.
    always_comb begin
        valid_d     = 1'b0;
        rd_d        = '0;
        alu_op_d    = '0;
        src_imm_d   = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        op_a_d      = '0;
        op_b_d      = '0;
        imm_d       = '0;
        if (!flush && !hazard && id_valid) begin
            valid_d     = 1'b1;
            rd_d        = id_rd;
            alu_op_d    = id_alu_op;
            src_imm_d   = id_alu_src_imm;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
            op_a_d      = fwd_a;
            op_b_d      = fwd_b;
            imm_d       = id_imm;
        end
    end

    // Saturating count of load-use stall cycles.
    always_comb begin
        count_d = count_q;
        if (stall_out && count_q != '1)
            count_d = count_q + 1'b1;
    end

    // Pipeline register and counter update with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rd_q        <= '0;
            alu_op_q    <= '0;
            src_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            imm_q       <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            alu_op_q    <= alu_op_d;
            src_imm_q   <= src_imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            imm_q       <= imm_d;
            count_q     <= count_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_rd          = rd_q;
    assign ex_alu_op      = alu_op_q;
    assign ex_alu_src_imm = src_imm_q;
    assign ex_reg_write   = reg_write_q;
    assign ex_mem_read    = mem_read_q;
    assign ex_mem_write   = mem_write_q;
    assign ex_op_a        = op_a_q;
    assign ex_op_b        = op_b_q;
    assign ex_imm         = imm_q;
    assign stall_count    = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a
// behavioural model of the execute-stage bundle.
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned OW = 4;
    // Narrow counter so saturation is reachable in a short run.
    localparam int unsigned CW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rt;
    logic [DW-1:0] id_rdata1, id_rdata2, id_imm;
    logic [OW-1:0] id_alu_op;
    logic          id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
    logic [DW-1:0] ex_alu_result;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          wb_we;
    logic          flush;
    logic          stall_out;
    logic          ex_valid;
    logic [AW-1:0] ex_rd;
    logic [OW-1:0] ex_alu_op;
    logic          ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [DW-1:0] ex_op_a, ex_op_b, ex_imm;
    logic [CW-1:0] stall_count;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .ALU_OP_W(OW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src_imm(id_alu_src_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .ex_alu_result(ex_alu_result),
        .wb_reg(wb_reg), .wb_data(wb_data), .wb_we(wb_we), .flush(flush),
        .stall_out(stall_out), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_imm(ex_imm), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit      valid;
        bit [AW-1:0] rd;
        bit [OW-1:0] op;
        bit      src_imm, rw, mr, mw;
        bit [DW-1:0] a, b, imm;
    } ex_t;

    ex_t m;
    int  m_cnt;
    int  passed = 0;
    int  total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Value the execute stage should see for a source register.
    function automatic bit [DW-1:0] model_operand(input bit [AW-1:0] r, input bit [DW-1:0] rf);
        if (r == 0) return '0;
        if (m.valid && m.rw && !m.mr && m.rd == r) return ex_alu_result;
        if (wb_we && wb_reg == r) return wb_data;
        return rf;
    endfunction

    function automatic bit model_load_use();
        bit dep;
        dep = (m.rd == id_rs) || (id_uses_rt && m.rd == id_rt);
        return id_valid && m.valid && m.mr && m.rd != 0 && dep;
    endfunction

    task automatic check_outputs();
        check("ex_valid", 64'(ex_valid), 64'(m.valid));
        check("ex_rd", 64'(ex_rd), 64'(m.rd));
        check("ex_alu_op", 64'(ex_alu_op), 64'(m.op));
        check("ex_alu_src_imm", 64'(ex_alu_src_imm), 64'(m.src_imm));
        check("ex_reg_write", 64'(ex_reg_write), 64'(m.rw));
        check("ex_mem_read", 64'(ex_mem_read), 64'(m.mr));
        check("ex_mem_write", 64'(ex_mem_write), 64'(m.mw));
        check("ex_op_a", 64'(ex_op_a), 64'(m.a));
        check("ex_op_b", 64'(ex_op_b), 64'(m.b));
        check("ex_imm", 64'(ex_imm), 64'(m.imm));
        check("stall_count", 64'(stall_count), 64'(m_cnt));
    endtask

    // One clock: check stall_out before the edge, advance model, check after.
    task automatic step(input bit chk_stall);
        bit   haz, stl;
        ex_t  nx;
        #2;
        haz = model_load_use();
        stl = haz && !flush;
        if (chk_stall) check("stall_out", 64'(stall_out), 64'(stl));
        nx = '{default: 0};
        if (!flush && !haz && id_valid) begin
            nx.valid = 1; nx.rd = id_rd; nx.op = id_alu_op;
            nx.src_imm = id_alu_src_imm; nx.rw = id_reg_write;
            nx.mr = id_mem_read; nx.mw = id_mem_write;
            nx.a = model_operand(id_rs, id_rdata1);
            nx.b = model_operand(id_rt, id_rdata2);
            nx.imm = id_imm;
        end
        if (reset) begin
            m = '{default: 0};
            m_cnt = 0;
        end else begin
            m = nx;
            if (stl && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic set_instr(input bit [AW-1:0] rs, input bit [AW-1:0] rt, input bit uses_rt,
                             input bit [AW-1:0] rd, input bit rw, input bit mr, input bit mw);
        id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
        id_alu_op = 4'($urandom); id_alu_src_imm = 1'($urandom); id_imm = $urandom;
        id_rdata1 = $urandom; id_rdata2 = $urandom;
    endtask

    task automatic quiet_side();
        wb_we = 0; wb_reg = 0; wb_data = $urandom; ex_alu_result = $urandom; flush = 0;
    endtask

    initial begin
        m = '{default: 0};
        m_cnt = 0;
        reset = 1;
        quiet_side();
        set_instr(5'd1, 5'd2, 1, 5'd3, 1, 0, 0);

        // Reset held two cycles with a valid instruction in decode.
        step(0);
        step(1);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_op_a", 64'(ex_op_a), 64'd0);
        check("rst_stall_count", 64'(stall_count), 64'd0);
        check("rst_stall_out", 64'(stall_out), 64'd0);
        reset = 0;

        // EX forwarding: add r3 then a reader of r3 with stale regfile data.
        set_instr(5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        step(1);
        set_instr(5'd3, 5'd0, 0, 5'd5, 1, 0, 0);
        id_rdata1 = 32'h5; ex_alu_result = 32'h11;
        step(1);
        check("ex_fwd_a", 64'(ex_op_a), 64'h11);

        // WB forwarding on rt, and r0 never forwarded.
        set_instr(5'd1, 5'd7, 1, 5'd6, 1, 0, 1);
        id_rdata2 = 0; wb_we = 1; wb_reg = 5'd7; wb_data = 32'hDEADBEEF;
        step(1);
        check("wb_fwd_b", 64'(ex_op_b), 64'hDEADBEEF);
        set_instr(5'd1, 5'd0, 1, 5'd6, 1, 0, 0);
        wb_reg = 5'd0;
        step(1);
        check("r0_b", 64'(ex_op_b), 64'd0);
        quiet_side();

        // Load-use: one stall, bubble, then WB-forwarded load data.
        set_instr(5'd1, 5'd2, 0, 5'd4, 1, 1, 0);
        step(1);
        set_instr(5'd4, 5'd2, 0, 5'd8, 1, 0, 0);
        step(1);
        check("lu_bubble", 64'(ex_valid), 64'd0);
        check("lu_count", 64'(stall_count), 64'd1);
        wb_we = 1; wb_reg = 5'd4; wb_data = 32'h42;
        step(1);
        check("lu_fwd", 64'(ex_op_a), 64'h42);
        quiet_side();

        // Load-use together with flush: flush wins, no stall counted.
        set_instr(5'd1, 5'd2, 0, 5'd4, 1, 1, 0);
        step(1);
        set_instr(5'd2, 5'd4, 1, 5'd8, 1, 0, 0);
        flush = 1;
        step(1);
        check("fl_bubble", 64'(ex_valid), 64'd0);
        check("fl_count", 64'(stall_count), 64'd1);
        flush = 0;

        // Random traffic over a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                      5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));
            id_valid = ($urandom_range(0, 3) != 0);
            ex_alu_result = $urandom;
            wb_we = 1'($urandom); wb_reg = 5'($urandom_range(0, 3)); wb_data = $urandom;
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 63) == 0);
            step(1);
        end
        reset = 0;
        quiet_side();

        // Counter saturation via repeated load / dependent pairs.
        step(1);
        for (int i = 0; i < (1 << CW) + 8; i++) begin
            set_instr(5'd1, 5'd2, 0, 5'd4, 1, 1, 0);
            step(1);
            set_instr(5'd4, 5'd2, 0, 5'd9, 1, 0, 0);
            step(1);
        end
        check("sat_count", 64'(stall_count), 64'((1 << CW) - 1));

        // Reset during a stall abandons it.
        set_instr(5'd1, 5'd2, 0, 5'd4, 1, 1, 0);
        step(1);
        set_instr(5'd4, 5'd2, 0, 5'd9, 1, 0, 0);
        reset = 1;
        step(1);
        check("rst_mid_count", 64'(stall_count), 64'd0);
        check("rst_mid_valid", 64'(ex_valid), 64'd0);
        reset = 0;
        step(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
